// File: rtl/snake_motion_engine_if.sv
// Interface bundling the navigation, growth, query and status signals of the
// snake motion engine.
//   master : control/render side. Drives Navigation_State, GROW, QUERY_X/Y and
//            observes HEAD_X/Y, SNAKE_LEN, MOVE_TICK, DEAD, HEAD_HIT, BODY_HIT.
//   slave  : the motion engine itself.
interface snake_motion_engine_if #(
  parameter int unsigned X_W = 6,
  parameter int unsigned Y_W = 5
);
  logic [1:0]     Navigation_State;
  logic           GROW;
  logic [X_W-1:0] QUERY_X;
  logic [Y_W-1:0] QUERY_Y;
  logic [X_W-1:0] HEAD_X;
  logic [Y_W-1:0] HEAD_Y;
  logic [6:0]     SNAKE_LEN;
  logic           MOVE_TICK;
  logic           DEAD;
  logic           HEAD_HIT;
  logic           BODY_HIT;

  modport master (
    output Navigation_State, GROW, QUERY_X, QUERY_Y,
    input  HEAD_X, HEAD_Y, SNAKE_LEN, MOVE_TICK, DEAD, HEAD_HIT, BODY_HIT
  );

  modport slave (
    input  Navigation_State, GROW, QUERY_X, QUERY_Y,
    output HEAD_X, HEAD_Y, SNAKE_LEN, MOVE_TICK, DEAD, HEAD_HIT, BODY_HIT
  );
endinterface

// File: rtl/snake_motion_engine.sv
// Snake motion engine: steps the snake one grid cell every TICK_DIV clocks,
// keeps body segments in a shift chain, handles growth, detects wall and
// self collisions and answers registered "is cell (x,y) snake?" queries.
// Ports:
//   CLK   : system clock
//   RESET : synchronous, active-high reset
//   bus   : snake_motion_engine_if.slave (direction, grow, query in;
//           head position, length, move tick, dead, query hits out)
module snake_motion_engine #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned X_W      = 6,
  parameter int unsigned Y_W      = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  snake_motion_engine_if.slave   bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LEN_W = 7;
  localparam int unsigned XW1   = X_W + 1;
  localparam int unsigned YW1   = Y_W + 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic {ST_RUN = 1'b0, ST_DEAD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     seg_x_q [MAX_LEN];
  logic [X_W-1:0]     seg_x_d [MAX_LEN];
  logic [Y_W-1:0]     seg_y_q [MAX_LEN];
  logic [Y_W-1:0]     seg_y_d [MAX_LEN];
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grow_pend_q, grow_pend_d;
  logic               move_tick_q, move_tick_d;
  logic               head_hit_q, head_hit_d;
  logic               body_hit_q, body_hit_d;

  logic               tick_c;
  logic               grow_eff_c;
  logic [1:0]         dir_c;
  logic [XW1-1:0]     nx_c;
  logic [YW1-1:0]     ny_c;
  logic               wall_c;
  logic               self_c;
  logic               in_grid_c;

  // Next-state, move and query evaluation
  always_comb begin
    state_d     = state_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    grow_pend_d = grow_pend_q;
    move_tick_d = 1'b0;
    head_hit_d  = 1'b0;
    body_hit_d  = 1'b0;
    self_c      = 1'b0;
    wall_c      = 1'b0;

    tick_c     = (state_q == ST_RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));
    grow_eff_c = grow_pend_q | bus.GROW;

    // Up/Down and Left/Right codes differ only in bit 0: a reversal is XOR == 01
    dir_c = ((bus.Navigation_State ^ dir_q) == 2'b01) ? dir_q : bus.Navigation_State;

    // Head step computed one bit wider so an edge step never aliases into the grid
    nx_c = {1'b0, seg_x_q[0]};
    ny_c = {1'b0, seg_y_q[0]};
    case (dir_c)
      DIR_UP: begin
        ny_c   = ny_c - YW1'(1);
        wall_c = (seg_y_q[0] == '0);
      end
      DIR_DOWN: begin
        ny_c   = ny_c + YW1'(1);
        wall_c = (seg_y_q[0] == Y_W'(GRID_H - 1));
      end
      DIR_LEFT: begin
        nx_c   = nx_c - XW1'(1);
        wall_c = (seg_x_q[0] == '0);
      end
      DIR_RIGHT: begin
        nx_c   = nx_c + XW1'(1);
        wall_c = (seg_x_q[0] == X_W'(GRID_W - 1));
      end
      default: ;
    endcase

    // Tail cell is only an obstacle when it stays put because of growth
    for (int unsigned k = 1; k < MAX_LEN; k++) begin
      if (((LEN_W'(k) < (len_q - LEN_W'(1))) ||
           (grow_eff_c && (LEN_W'(k) == (len_q - LEN_W'(1))))) &&
          ({1'b0, seg_x_q[k]} == nx_c) && ({1'b0, seg_y_q[k]} == ny_c)) begin
        self_c = 1'b1;
      end
    end

    if (state_q == ST_RUN) begin
      if (tick_c) begin
        cnt_d       = '0;
        move_tick_d = 1'b1;
        grow_pend_d = 1'b0;
        if (wall_c || self_c) begin
          state_d = ST_DEAD;
        end else begin
          for (int unsigned k = 1; k < MAX_LEN; k++) begin
            seg_x_d[k] = seg_x_q[k-1];
            seg_y_d[k] = seg_y_q[k-1];
          end
          seg_x_d[0] = nx_c[X_W-1:0];
          seg_y_d[0] = ny_c[Y_W-1:0];
          dir_d      = dir_c;
          if (grow_eff_c && (len_q < LEN_W'(MAX_LEN))) begin
            len_d = len_q + LEN_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.GROW) begin
          grow_pend_d = 1'b1;
        end
      end
    end

    // Query port stays live in every state
    in_grid_c = ({1'b0, bus.QUERY_X} < XW1'(GRID_W)) &&
                ({1'b0, bus.QUERY_Y} < YW1'(GRID_H));
    head_hit_d = in_grid_c && (bus.QUERY_X == seg_x_q[0]) && (bus.QUERY_Y == seg_y_q[0]);
    for (int unsigned k = 1; k < MAX_LEN; k++) begin
      if (in_grid_c && (LEN_W'(k) < len_q) &&
          (bus.QUERY_X == seg_x_q[k]) && (bus.QUERY_Y == seg_y_q[k])) begin
        body_hit_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= (k < 3) ? X_W'(GRID_W / 2) : '0;
        seg_y_q[k] <= (k < 3) ? Y_W'(GRID_H / 2 + k) : '0;
      end
      len_q       <= LEN_W'(3);
      dir_q       <= DIR_UP;
      cnt_q       <= '0;
      grow_pend_q <= 1'b0;
      move_tick_q <= 1'b0;
      head_hit_q  <= 1'b0;
      body_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      grow_pend_q <= grow_pend_d;
      move_tick_q <= move_tick_d;
      head_hit_q  <= head_hit_d;
      body_hit_q  <= body_hit_d;
    end
  end

  assign bus.HEAD_X    = seg_x_q[0];
  assign bus.HEAD_Y    = seg_y_q[0];
  assign bus.SNAKE_LEN = len_q;
  assign bus.MOVE_TICK = move_tick_q;
  assign bus.DEAD      = (state_q == ST_DEAD);
  assign bus.HEAD_HIT  = head_hit_q;
  assign bus.BODY_HIT  = body_hit_q;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine (TICK_DIV=4, MAX_LEN=6).
module tb_snake_motion_engine;

  localparam int unsigned GW = 40;
  localparam int unsigned GH = 30;
  localparam int unsigned ML = 6;
  localparam int unsigned TD = 4;
  localparam int unsigned XW = 6;
  localparam int unsigned YW = 5;

  localparam logic [1:0] U = 2'b00;
  localparam logic [1:0] D = 2'b01;
  localparam logic [1:0] L = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_motion_engine_if #(.X_W(XW), .Y_W(YW)) bus ();

  snake_motion_engine #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .TICK_DIV(TD), .X_W(XW), .Y_W(YW)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0] nav_mid;
    logic [1:0] nav_tick;
    logic       g_mid;
    logic       g_tick;
    int         hx;
    int         hy;
    int         len;
  } vec_t;

  vec_t vecs [12];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Navigation_State = U;
    bus.GROW = 1'b0;
    edge1();
    edge1();
    rst = 1'b0;
  endtask

  // One full move interval starting with the counter at 0; ends just after the move edge
  task automatic run_tick(input logic [1:0] nav_mid, input logic [1:0] nav_tick,
                          input logic g_mid, input logic g_tick, input string tag);
    bus.Navigation_State = nav_mid;
    edge1();
    bus.GROW = g_mid;
    edge1();
    bus.GROW = 1'b0;
    edge1();
    check({tag, " tick_pre"}, 32'(bus.MOVE_TICK), 32'd0);
    bus.Navigation_State = nav_tick;
    bus.GROW = g_tick;
    edge1();
    bus.GROW = 1'b0;
    check({tag, " tick_on"}, 32'(bus.MOVE_TICK), 32'd1);
  endtask

  task automatic query(input int qx, input int qy, input logic eh, input logic eb, input string tag);
    bus.QUERY_X = XW'(qx);
    bus.QUERY_Y = YW'(qy);
    edge1();
    check({tag, " head_hit"}, 32'(bus.HEAD_HIT), 32'(eh));
    check({tag, " body_hit"}, 32'(bus.BODY_HIT), 32'(eb));
  endtask

  task automatic check_head(input int hx, input int hy, input int len, input logic dead, input string tag);
    check({tag, " hx"}, 32'(bus.HEAD_X), 32'(hx));
    check({tag, " hy"}, 32'(bus.HEAD_Y), 32'(hy));
    check({tag, " len"}, 32'(bus.SNAKE_LEN), 32'(len));
    check({tag, " dead"}, 32'(bus.DEAD), 32'(dead));
  endtask

  initial begin
    int mt_seen;

    // nav_mid, nav_tick, g_mid, g_tick, head x, head y, len  (start (20,15) heading Up)
    vecs[0]  = '{R, U, 1'b0, 1'b0, 20, 14, 3};  // mid-interval change ignored
    vecs[1]  = '{U, D, 1'b0, 1'b0, 20, 13, 3};  // reversal refused
    vecs[2]  = '{D, L, 1'b0, 1'b0, 19, 13, 3};
    vecs[3]  = '{D, D, 1'b0, 1'b0, 19, 14, 3};
    vecs[4]  = '{R, R, 1'b0, 1'b0, 20, 14, 3};
    vecs[5]  = '{R, L, 1'b0, 1'b0, 21, 14, 3};  // reversal refused
    vecs[6]  = '{R, R, 1'b1, 1'b0, 22, 14, 4};  // pending grow
    vecs[7]  = '{D, D, 1'b0, 1'b1, 22, 15, 5};  // grow on the move cycle
    vecs[8]  = '{D, D, 1'b1, 1'b1, 22, 16, 6};  // two pulses collapse to one
    vecs[9]  = '{D, D, 1'b1, 1'b1, 22, 17, 6};  // capped at MAX_LEN
    vecs[10] = '{D, D, 1'b0, 1'b0, 22, 18, 6};
    vecs[11] = '{U, U, 1'b0, 1'b0, 22, 19, 6};  // reversal refused

    bus.Navigation_State = U;
    bus.GROW    = 1'b0;
    bus.QUERY_X = XW'(63);
    bus.QUERY_Y = YW'(31);

    // Reset state
    do_reset();
    check_head(20, 15, 3, 1'b0, "rst");
    check("rst move_tick", 32'(bus.MOVE_TICK), 32'd0);
    check("rst head_hit", 32'(bus.HEAD_HIT), 32'd0);
    check("rst body_hit", 32'(bus.BODY_HIT), 32'd0);

    // Query port against the reset snake (first move lands on the 4th edge)
    query(20, 15, 1'b1, 1'b0, "q_head");
    query(20, 16, 1'b0, 1'b1, "q_seg1");
    query(20, 17, 1'b0, 1'b1, "q_seg2");
    query(20, 18, 1'b0, 1'b0, "q_none");
    check("q first move", 32'(bus.MOVE_TICK), 32'd1);
    check("q first hy", 32'(bus.HEAD_Y), 32'd14);
    query(45, 3, 1'b0, 1'b0, "q_outside");

    // Reset landing on the move edge wins
    do_reset();
    edge1(); edge1(); edge1();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    check("rst_mid move_tick", 32'(bus.MOVE_TICK), 32'd0);
    check_head(20, 15, 3, 1'b0, "rst_mid");

    // Table-driven movement, steering and growth
    for (int i = 0; i < 12; i++) begin
      run_tick(vecs[i].nav_mid, vecs[i].nav_tick, vecs[i].g_mid, vecs[i].g_tick, $sformatf("v%0d", i));
      check_head(vecs[i].hx, vecs[i].hy, vecs[i].len, 1'b0, $sformatf("v%0d", i));
    end

    // Wall collision on the left edge
    do_reset();
    for (int i = 0; i < 20; i++) run_tick(L, L, 1'b0, 1'b0, "wall_run");
    check_head(0, 15, 3, 1'b0, "wall_edge");
    run_tick(L, L, 1'b0, 1'b0, "wall_hit");
    check_head(0, 15, 3, 1'b1, "wall_hit");
    query(1, 15, 1'b0, 1'b1, "dead_seg1");
    query(2, 15, 1'b0, 1'b1, "dead_seg2");
    query(3, 15, 1'b0, 1'b0, "dead_past_tail");
    query(0, 15, 1'b1, 1'b0, "dead_head");
    mt_seen = 0;
    bus.GROW = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge1();
      if (bus.MOVE_TICK) mt_seen++;
    end
    bus.GROW = 1'b0;
    check("dead no ticks", 32'(mt_seen), 32'd0);
    check_head(0, 15, 3, 1'b1, "dead_frozen");
    do_reset();
    check_head(20, 15, 3, 1'b0, "dead_reset");

    // Self collision with LEN=5: head enters a live body cell
    do_reset();
    run_tick(U, U, 1'b1, 1'b0, "s5");
    run_tick(U, U, 1'b0, 1'b1, "s5");
    check_head(20, 13, 5, 1'b0, "s5_grown");
    run_tick(L, L, 1'b0, 1'b0, "s5");
    run_tick(D, D, 1'b0, 1'b0, "s5");
    check_head(19, 14, 5, 1'b0, "s5_turned");
    run_tick(R, R, 1'b0, 1'b0, "s5_hit");
    check_head(19, 14, 5, 1'b1, "s5_hit");

    // Same loop with LEN=4: target is the vacating tail, legal
    do_reset();
    run_tick(U, U, 1'b0, 1'b1, "s4");
    run_tick(U, U, 1'b0, 1'b0, "s4");
    run_tick(L, L, 1'b0, 1'b0, "s4");
    run_tick(D, D, 1'b0, 1'b0, "s4");
    run_tick(R, R, 1'b0, 1'b0, "s4_tail");
    check_head(20, 14, 4, 1'b0, "s4_tail");

    // LEN=4 loop with a grow on the final move: tail stays, so it is fatal
    do_reset();
    run_tick(U, U, 1'b0, 1'b1, "s4g");
    run_tick(U, U, 1'b0, 1'b0, "s4g");
    run_tick(L, L, 1'b0, 1'b0, "s4g");
    run_tick(D, D, 1'b0, 1'b0, "s4g");
    run_tick(R, R, 1'b0, 1'b1, "s4g_hit");
    check_head(19, 14, 4, 1'b1, "s4g_hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
